// File: rtl/img_op_pkg.sv
// img_op_pkg: shared constants, opcodes and state type for img_op_engine
package img_op_pkg;
    localparam int IMG_DIM = 8;
    localparam int WIN_DIM = 4;
    localparam int N_OPS   = 15;
    localparam int PIX_W   = 7;
    localparam logic [2:0] ORG_RST = 3'd2;
    localparam logic [2:0] ORG_MAX = 3'(IMG_DIM - WIN_DIM);
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_UP    = 4'd1;
    localparam logic [3:0] OP_DOWN  = 4'd2;
    localparam logic [3:0] OP_LEFT  = 4'd3;
    localparam logic [3:0] OP_RIGHT = 4'd4;
    localparam logic [3:0] OP_NEG   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_FLIP  = 4'd7;
    typedef enum logic [1:0] {IDLE, LOAD, PROC, OUT} state_t;
endpackage

// File: rtl/pix_alu.sv
// pix_alu: per-pixel saturating negate / floor-halving, pass-through otherwise
//   pix_in  : signed pixel
//   op      : current opcode
//   pix_out : processed pixel
module pix_alu
    import img_op_pkg::*;
(
    input  logic signed [PIX_W-1:0] pix_in,
    input  logic        [3:0]       op,
    output logic signed [PIX_W-1:0] pix_out
);
    localparam logic signed [PIX_W-1:0] PIX_MIN = {1'b1, {(PIX_W-1){1'b0}}};
    localparam logic signed [PIX_W-1:0] PIX_MAX = ~PIX_MIN;
    // most negative value has no positive twin, so it clamps to the max
    always_comb begin
        pix_out = (op == OP_NEG) ? ((pix_in == PIX_MIN) ? PIX_MAX : -pix_in) :
                  (op == OP_SHR) ? (pix_in >>> 1) : pix_in;
    end
endmodule

// File: rtl/img_op_engine.sv
// img_op_engine: loads an 8x8 image plus 15 opcodes, applies them, emits a 4x4 window
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : 64-cycle pixel burst; in_data signed pixel; op opcode (first 15 cycles)
//   out_valid  : 16-cycle window burst; out_data signed pixel, 0 when idle
module img_op_engine
    import img_op_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [PIX_W-1:0] in_data,
    input  logic        [3:0]       op,
    output logic                    out_valid,
    output logic signed [PIX_W-1:0] out_data
);
    localparam int N_PIX = IMG_DIM * IMG_DIM;
    state_t                  state;
    logic [5:0]              cnt;
    logic [2:0]              r, c;
    logic signed [PIX_W-1:0] pix [N_PIX];
    logic signed [PIX_W-1:0] nxt [N_PIX];
    logic [3:0]              ops [N_OPS];
    logic [3:0]              cur_op;
    logic [2:0]              wr, wc;
    assign cur_op = (cnt < 6'(N_OPS)) ? ops[cnt[3:0]] : OP_NOP;
    // window walk: cnt[3:2] is the row offset, cnt[1:0] the column offset
    assign wr = r + {1'b0, cnt[3:2]};
    assign wc = c + {1'b0, cnt[1:0]};
    for (genvar i = 0; i < N_PIX; i++) begin : g_pix
        localparam int FLIP_IDX = (i / IMG_DIM) * IMG_DIM + (IMG_DIM - 1 - i % IMG_DIM);
        logic signed [PIX_W-1:0] alu_out;
        pix_alu u_alu (
            .pix_in  (pix[i]),
            .op      (cur_op),
            .pix_out (alu_out)
        );
        assign nxt[i] = (cur_op == OP_FLIP) ? pix[FLIP_IDX] : alu_out;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            r         <= ORG_RST;
            c         <= ORG_RST;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < N_PIX; i++) pix[i] <= '0;
            for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
        end else begin
            out_valid <= (state == OUT);
            out_data  <= (state == OUT) ? pix[{wr, wc}] : '0;
            case (state)
                IDLE: if (in_valid) begin
                    pix[0] <= in_data;
                    ops[0] <= op;
                    cnt    <= 6'd1;
                    r      <= ORG_RST;
                    c      <= ORG_RST;
                    state  <= LOAD;
                end
                LOAD: if (in_valid) begin
                    pix[cnt] <= in_data;
                    if (cnt < 6'(N_OPS)) ops[cnt[3:0]] <= op;
                    // cnt wraps to 0 after the last sample, ready to index opcodes
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(N_PIX - 1)) state <= PROC;
                end
                PROC: begin
                    for (int i = 0; i < N_PIX; i++) pix[i] <= nxt[i];
                    r <= (cur_op == OP_UP    && r != 3'd0)    ? r - 3'd1 :
                         (cur_op == OP_DOWN  && r != ORG_MAX) ? r + 3'd1 : r;
                    c <= (cur_op == OP_LEFT  && c != 3'd0)    ? c - 3'd1 :
                         (cur_op == OP_RIGHT && c != ORG_MAX) ? c + 3'd1 : c;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(N_OPS - 1)) begin
                        cnt   <= '0;
                        state <= OUT;
                    end
                end
                OUT: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(WIN_DIM * WIN_DIM - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/img_op_engine.md
IMG_OP_ENGINE -- requirements
Module: img_op_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  high for exactly 64 consecutive cycles per pattern.
REQ-005 in_data  input  7  signed pixel; 8x8 image, row-major, sampled while in_valid=1.
REQ-006 op  input  4  opcode; valid during the first 15 in_valid cycles only, don't-care after.
REQ-007 out_valid  output  1  high for exactly 16 consecutive cycles per pattern.
REQ-008 out_data  output  7  signed window pixel, row-major; 0 whenever out_valid=0.

Function
REQ-009 The FSM SHALL have states IDLE, LOAD, PROC and OUT; IDLE->LOAD on in_valid=1; LOAD->PROC after the 64th sample; PROC->OUT after 15 cycles; OUT->IDLE after 16 cycles.
REQ-010 The block SHALL store the 64 pixels in a register array and the 15 opcodes in a 15x4 queue, both indexed by a 6-bit input counter.
REQ-011 The block SHALL initialise the window origin (r,c) to (2,2) at the first in_valid cycle of every pattern.
REQ-012 The PROC state SHALL apply one opcode per cycle, in arrival order.
REQ-013 Opcodes: 0 NOP; 1 r-1; 2 r+1; 3 c-1; 4 c+1; 5 negate all 64 pixels; 6 arithmetic shift right by 1 on all 64 pixels; 7 horizontal flip of the whole image (col c <-> col 7-c); 8-15 NOP.
REQ-014 The window moves (opcodes 1-4) SHALL saturate r and c to the range 0..4; a move at a limit leaves the origin unchanged.
REQ-015 Negate SHALL saturate so that -64 becomes 63; all other values map to -x.
REQ-016 Shift SHALL round toward minus infinity (-1 -> -1, -3 -> -2).
REQ-017 The OUT state SHALL emit the 4x4 window at (r,c) in row-major order, one pixel per cycle.
REQ-018 Latency: the first out_valid=1 SHALL occur on the 16th rising edge after the edge that samples the 64th pixel.
REQ-019 The block SHALL accept a new pattern whose in_valid rises on the cycle immediately after out_valid falls.
REQ-020 The block SHALL ignore in_valid asserted during PROC or OUT (protocol violation); image, opcodes and outputs are unaffected.
REQ-021 out_valid and out_data SHALL be registered outputs.

Reset
REQ-022 While rst_n=0: state=IDLE, counters=0, out_valid=0, out_data=0, origin=(2,2), and the pixel array and opcode queue are cleared to 0.
REQ-023 Reset asserted mid-LOAD, mid-PROC or mid-OUT SHALL abort the pattern with no further out_valid pulses; the next in_valid starts a fresh pattern.

Structure
REQ-024 Shared package img_op_pkg SHALL hold: the opcode localparams (OP_NOP..OP_FLIP), the state enum, IMG_DIM=8, WIN_DIM=4, N_OPS=15, PIX_W=7, and the origin reset value 2.
REQ-025 The per-pixel negate/shift datapath SHALL be a sub-module pix_alu (7-bit in, opcode in, 7-bit out), instantiated 64 times.

Verification
REQ-026 Reset: rst_n=0 with in_valid=0 -> out_valid=0 and out_data=0 within the reset pulse.
REQ-027 All opcodes 0, pixel[i]=i-32 -> outputs -14,-13,-12,-11,-6,...,13; first output on the 16th edge after the last sample.
REQ-028 Opcodes 1,1,1,3,3,3 followed by NOPs, same image -> origin saturates at (0,0); outputs -32,-31,-30,-29,-24,...,-5.
REQ-029 Opcode 5 with all pixels -64 -> 16 outputs of 63. Opcodes 6,6 with all pixels 63 -> 16 outputs of 15. Opcode 6 with all pixels -3 -> 16 outputs of -2.
REQ-030 Opcode 7, pixel=column index -> each output row reads 5,4,3,2.
REQ-031 Back-to-back: pattern 2 in_valid rises the cycle after pattern 1 out_valid falls -> pattern 2 output is correct with the origin restarted at (2,2); a reset pulse during OUT -> out_valid drops immediately and stays 0.
